fetch_align_ctrl: RTL and testbench
===================================

FETCH_ALIGN_CTRL -- requirements
Module: fetch_align_ctrl

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000, is the first instruction address after reset.
REQ-002: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: fetch_addr  output  32  word-aligned address of the next fetch word; bits [1:0] always 2'b00.
REQ-005: fetch_rvalid  input  1  fetch_rdata holds the word at fetch_addr this cycle.
REQ-006: fetch_rdata  input  32  fetched word; its low half sits at fetch_addr and its high half at fetch_addr+2.
REQ-007: fetch_ready  output  1  combinational; the block consumes fetch_rdata this cycle.
REQ-008: inst_valid  output  1  combinational; an aligned instruction is presented to decode.
REQ-009: inst_ready  input  1  decode accepts the instruction this cycle.
REQ-010: inst_data  output  32  full instruction, or {16'h0000, halfword} when compressed.
REQ-011: inst_pc  output  32  address of the presented instruction.
REQ-012: inst_compressed  output  1  presented instruction is 16-bit; it is sent to the downstream decompressor.
REQ-013: redirect_valid  input  1  a jump, branch or trap redirects fetch this cycle.
REQ-014: redirect_pc  input  32  target; bit 0 is ignored.

Function
REQ-015: A halfword h is compressed when h[1:0] != 2'b11.
REQ-016: The state machine has three states: EMPTY (no held half), SKIP (discard the low half of the next word), and HALF (hold_data[15:0] is valid at hold_pc).
REQ-017: The 16-bit hold_data and 32-bit hold_pc registers are meaningful only in HALF.
REQ-018: EMPTY, fetch_rvalid, low half full: present fetch_rdata at fetch_addr as a 32-bit instruction; fetch_ready=inst_ready; stay EMPTY.
REQ-019: EMPTY, fetch_rvalid, low half compressed: present the low half at fetch_addr; fetch_ready=inst_ready; on consume, hold_data<=rdata[31:16], hold_pc<=fetch_addr+2, and go to HALF.
REQ-020: SKIP with fetch_rvalid: inst_valid=0 and fetch_ready=1; hold_data<=rdata[31:16], hold_pc<=fetch_addr+2, and go to HALF.
REQ-021: HALF with a compressed hold: present hold_data at hold_pc with fetch_ready=0 and no dependence on fetch_rvalid; on inst_ready, go to EMPTY.
REQ-022: HALF with a full hold: present {rdata[15:0], hold_data} at hold_pc only while fetch_rvalid; fetch_ready=inst_ready; on consume, reload the hold from rdata[31:16] at fetch_addr+2 and stay in HALF.
REQ-023: fetch_addr increments by 4 on every consumed word (fetch_rvalid & fetch_ready); it wraps modulo 2^32.
REQ-024: inst_valid=0 whenever the required fetch word is absent; inst_data, inst_pc and inst_compressed are then don't-care.
REQ-025: Redirect has top priority: inst_valid=0 and fetch_ready=0 that cycle.
REQ-026: On redirect, the next fetch_addr is {redirect_pc[31:2], 2'b00}.
REQ-027: On redirect, the next state is SKIP if redirect_pc[1] is set, otherwise EMPTY.
REQ-028: Presented instruction fields stay stable while inst_valid & !inst_ready, unless a redirect occurs.
REQ-029: Latency from fetch word to instruction is zero cycles.
REQ-030: A 32-bit instruction straddling a word boundary emits in the cycle its second word arrives.
REQ-031: Two compressed instructions in one word take 2 cycles with a one-cycle fetch bubble.

Reset
REQ-032: On reset, fetch_addr <= {RESET_PC[31:2], 2'b00}.
REQ-033: On reset, the state becomes SKIP if RESET_PC[1] is set, else EMPTY.
REQ-034: On reset, hold_data and hold_pc clear to 0.
REQ-035: While reset is high, inst_valid=0 and fetch_ready=0.
REQ-036: Reset asserted mid-instruction discards any held half with no partial emission.

Structure
REQ-037: The state enum align_state_t {ALIGN_EMPTY, ALIGN_SKIP, ALIGN_HALF} belongs in shared package rvc_pkg.
REQ-038: The constants INST_ALIGN_BYTES=4 and HALF_BYTES=2 belong in shared package rvc_pkg.
REQ-039: The single sub-module is rvc_len_check (16-bit in, is_compressed out), instantiated once per examined half.
REQ-040: Each instance of rvc_len_check feeds the next-state and output logic.

Verification
REQ-041: Reset with RESET_PC=0, word 0x00B50533 -> inst 0x00B50533 at pc 0, not compressed, fetch_addr becomes 4.
REQ-042: Word 0x45054581 at pc 0 -> 0x4581 at pc 0 then 0x4505 at pc 2; the cycle between shows fetch_ready=0; fetch_addr advances once.
REQ-043: Word 0x05334581 then 0x000000B5 -> 0x4581 at pc 0, then 0x00B50533 at pc 2 when the second word arrives.
REQ-044: redirect_pc=0x102 -> fetch_addr=0x100; the low half of the next word is dropped; its high half is handled from HALF; the first inst_pc is 0x102.
REQ-045: inst_ready held low 5 cycles while HALF holds a full-length half -> outputs stable, fetch_addr unchanged, then a single accept.
REQ-046: redirect_valid together with inst_valid & inst_ready in HALF -> no emission, hold discarded, fetch_addr = aligned target the next cycle.

Source files
------------

// File: rtl/rvc_pkg.sv
// Shared definitions for the compressed-instruction fetch alignment path.
package rvc_pkg;

    typedef enum logic [1:0] {
        ALIGN_EMPTY = 2'd0,
        ALIGN_SKIP  = 2'd1,
        ALIGN_HALF  = 2'd2
    } align_state_t;

    localparam logic [31:0] INST_ALIGN_BYTES = 32'd4;
    localparam logic [31:0] HALF_BYTES       = 32'd2;

    // A halfword opens a 16-bit instruction unless its low two bits are 2'b11.
    function automatic logic is_rvc_half(input logic [15:0] half);
        return (half[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/rvc_len_check.sv
// Length decode of a single halfword: flags the start of a 16-bit instruction.
module rvc_len_check
    import rvc_pkg::*;
(
    input  logic [15:0] half,
    output logic        is_compressed
);

    assign is_compressed = is_rvc_half(half);

endmodule

// File: rtl/fetch_align_ctrl.sv
// Aligns a stream of 32-bit fetch words into 16/32-bit instructions for decode,
// holding a leftover high half across word boundaries.
module fetch_align_ctrl
    import rvc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] fetch_addr,
    input  logic        fetch_rvalid,
    input  logic [31:0] fetch_rdata,
    output logic        fetch_ready,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_compressed,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    align_state_t state_r;
    align_state_t state_next_s;
    logic [31:0]  fetch_addr_r;
    logic [31:0]  fetch_addr_next_s;
    logic [15:0]  hold_data_r;
    logic [31:0]  hold_pc_r;
    logic         hold_load_s;
    logic         low_is_rvc_s;
    logic         hold_is_rvc_s;
    logic         unused_redirect_bit_s;

    assign unused_redirect_bit_s = redirect_pc[0];
    assign fetch_addr            = fetch_addr_r;

    rvc_len_check u_low_check (
        .half          (fetch_rdata[15:0]),
        .is_compressed (low_is_rvc_s)
    );

    rvc_len_check u_hold_check (
        .half          (hold_data_r),
        .is_compressed (hold_is_rvc_s)
    );

    // Next-state, hold-load and decode-facing outputs.
    always_comb begin
        state_next_s    = state_r;
        hold_load_s     = 1'b0;
        inst_valid      = 1'b0;
        fetch_ready     = 1'b0;
        inst_data       = fetch_rdata;
        inst_pc         = fetch_addr_r;
        inst_compressed = 1'b0;

        if (reset) begin
            state_next_s = state_r;
        end else if (redirect_valid) begin
            state_next_s = redirect_pc[1] ? ALIGN_SKIP : ALIGN_EMPTY;
        end else begin
            case (state_r)
                ALIGN_EMPTY: begin
                    if (fetch_rvalid) begin
                        inst_valid  = 1'b1;
                        fetch_ready = inst_ready;
                        if (low_is_rvc_s) begin
                            inst_data       = {16'h0000, fetch_rdata[15:0]};
                            inst_compressed = 1'b1;
                            if (inst_ready) begin
                                hold_load_s  = 1'b1;
                                state_next_s = ALIGN_HALF;
                            end else begin
                                state_next_s = ALIGN_EMPTY;
                            end
                        end else begin
                            state_next_s = ALIGN_EMPTY;
                        end
                    end else begin
                        state_next_s = ALIGN_EMPTY;
                    end
                end
                ALIGN_SKIP: begin
                    if (fetch_rvalid) begin
                        fetch_ready  = 1'b1;
                        hold_load_s  = 1'b1;
                        state_next_s = ALIGN_HALF;
                    end else begin
                        state_next_s = ALIGN_SKIP;
                    end
                end
                ALIGN_HALF: begin
                    inst_pc = hold_pc_r;
                    if (hold_is_rvc_s) begin
                        // The held half is a whole instruction; the fetch word waits.
                        inst_valid      = 1'b1;
                        inst_data       = {16'h0000, hold_data_r};
                        inst_compressed = 1'b1;
                        state_next_s    = inst_ready ? ALIGN_EMPTY : ALIGN_HALF;
                    end else if (fetch_rvalid) begin
                        inst_valid   = 1'b1;
                        inst_data    = {fetch_rdata[15:0], hold_data_r};
                        fetch_ready  = inst_ready;
                        hold_load_s  = inst_ready;
                        state_next_s = ALIGN_HALF;
                    end else begin
                        state_next_s = ALIGN_HALF;
                    end
                end
                default: begin
                    state_next_s = ALIGN_EMPTY;
                end
            endcase
        end
    end

    // Fetch address: redirect target, or advance by one word on each consume.
    always_comb begin
        fetch_addr_next_s = fetch_addr_r;
        if (redirect_valid) begin
            fetch_addr_next_s = {redirect_pc[31:2], 2'b00};
        end else if (fetch_rvalid && fetch_ready) begin
            fetch_addr_next_s = fetch_addr_r + INST_ALIGN_BYTES;
        end else begin
            fetch_addr_next_s = fetch_addr_r;
        end
    end

    // State, fetch address and held-half registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= RESET_PC[1] ? ALIGN_SKIP : ALIGN_EMPTY;
            fetch_addr_r <= {RESET_PC[31:2], 2'b00};
            hold_data_r  <= 16'h0000;
            hold_pc_r    <= 32'h0000_0000;
        end else begin
            state_r      <= state_next_s;
            fetch_addr_r <= fetch_addr_next_s;
            if (hold_load_s) begin
                hold_data_r <= fetch_rdata[31:16];
                hold_pc_r   <= fetch_addr_r + HALF_BYTES;
            end else begin
                hold_data_r <= hold_data_r;
                hold_pc_r   <= hold_pc_r;
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Directed bench for fetch_align_ctrl: expected instructions are queued as
// stimulus is issued and a negedge monitor checks every decode handshake.
module tb_fetch_align_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] fetch_addr;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        fetch_ready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_compressed;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    fetch_align_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_addr      (fetch_addr),
        .fetch_rvalid    (fetch_rvalid),
        .fetch_rdata     (fetch_rdata),
        .fetch_ready     (fetch_ready),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_compressed (inst_compressed),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] pc, input logic c);
        exp_t e;
        e.data = d;
        e.pc   = pc;
        e.comp = c;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs shortly after the rising edge, then settle.
    task automatic cyc(input logic rst, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        reset          = rst;
        fetch_rvalid   = rv;
        fetch_rdata    = rd;
        inst_ready     = ir;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 32'h0000_4581, 1'b1, 1'b0, 32'h0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst_fetch_addr", fetch_addr, 32'h0000_0000);
        chk("rst_idle_valid", {31'd0, inst_valid}, 32'd0);
    endtask

    // Scoreboard monitor: every accepted instruction must match the queue head.
    always @(negedge clk) begin
        if (!reset && inst_valid && inst_ready) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_inst: got data 0x%08h pc 0x%08h, none expected",
                         inst_data, inst_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (inst_data !== e.data || inst_pc !== e.pc || inst_compressed !== e.comp) begin
                    failures = failures + 1;
                    $display("FAIL inst: got data 0x%08h pc 0x%08h c %0b expected data 0x%08h pc 0x%08h c %0b",
                             inst_data, inst_pc, inst_compressed, e.data, e.pc, e.comp);
                end
            end
        end
    end

    initial begin
        clk            = 1'b0;
        reset          = 1'b1;
        fetch_rvalid   = 1'b0;
        fetch_rdata    = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        checks         = 0;
        failures       = 0;

        // Single 32-bit instruction in an aligned word.
        do_reset();
        push(32'h00B5_0533, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h00B5_0533, 1'b1, 1'b0, 32'h0);
        chk("full_valid", {31'd0, inst_valid}, 32'd1);
        chk("full_ready", {31'd0, fetch_ready}, 32'd1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("full_addr", fetch_addr, 32'h0000_0004);

        // Two compressed instructions in one word with a fetch bubble.
        do_reset();
        push(32'h0000_4581, 32'h0, 1'b1);
        push(32'h0000_4505, 32'h2, 1'b1);
        cyc(1'b0, 1'b1, 32'h4505_4581, 1'b1, 1'b0, 32'h0);
        chk("c2_first_comp", {31'd0, inst_compressed}, 32'd1);
        cyc(1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0);
        chk("c2_bubble_ready", {31'd0, fetch_ready}, 32'd0);
        chk("c2_second_pc", inst_pc, 32'h0000_0002);
        chk("c2_addr", fetch_addr, 32'h0000_0004);

        // 32-bit instruction straddling a word boundary.
        do_reset();
        push(32'h0000_4581, 32'h0, 1'b1);
        push(32'h00B5_0533, 32'h2, 1'b0);
        cyc(1'b0, 1'b1, 32'h0533_4581, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h0000_00B5, 1'b1, 1'b0, 32'h0);
        chk("straddle_data", inst_data, 32'h00B5_0533);
        chk("straddle_ready", {31'd0, fetch_ready}, 32'd1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("straddle_addr", fetch_addr, 32'h0000_0008);

        // Reset while a half is held discards it (do_reset checks no emission).
        do_reset();

        // Redirect to a half-word target skips the low half.
        cyc(1'b0, 1'b1, 32'h1111_2222, 1'b1, 1'b1, 32'h0000_0102);
        chk("redir_valid", {31'd0, inst_valid}, 32'd0);
        chk("redir_ready", {31'd0, fetch_ready}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("redir_addr", fetch_addr, 32'h0000_0100);
        chk("skip_idle_valid", {31'd0, inst_valid}, 32'd0);
        push(32'h0000_4505, 32'h0000_0102, 1'b1);
        cyc(1'b0, 1'b1, 32'h4505_4581, 1'b1, 1'b0, 32'h0);
        chk("skip_valid", {31'd0, inst_valid}, 32'd0);
        chk("skip_ready", {31'd0, fetch_ready}, 32'd1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("skip_pc", inst_pc, 32'h0000_0102);
        chk("skip_addr", fetch_addr, 32'h0000_0104);

        // Decode stall while a full-length half is held.
        push(32'h0000_4581, 32'h0000_0104, 1'b1);
        cyc(1'b0, 1'b1, 32'h0533_4581, 1'b1, 1'b0, 32'h0);
        push(32'h00B5_0533, 32'h0000_0106, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 32'h0000_00B5, 1'b0, 1'b0, 32'h0);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_data", inst_data, 32'h00B5_0533);
            chk("stall_pc", inst_pc, 32'h0000_0106);
            chk("stall_ready", {31'd0, fetch_ready}, 32'd0);
            chk("stall_addr", fetch_addr, 32'h0000_0108);
        end
        cyc(1'b0, 1'b1, 32'h0000_00B5, 1'b1, 1'b0, 32'h0);
        chk("stall_accept_ready", {31'd0, fetch_ready}, 32'd1);

        // Redirect beats a ready handshake in HALF; bit 0 of the target is ignored.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0201);
        chk("redir_half_valid", {31'd0, inst_valid}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("redir_half_addr", fetch_addr, 32'h0000_0200);
        chk("redir_half_empty", {31'd0, inst_valid}, 32'd0);

        // Fetch address wraps modulo 2^32.
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        push(32'h00B5_0533, 32'hFFFF_FFFC, 1'b0);
        cyc(1'b0, 1'b1, 32'h00B5_0533, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr", fetch_addr, 32'h0000_0000);

        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
